// File: rtl/input_skew_feeder_if.sv
// Activation stream in, skewed array drive out.
// The master side drives columns; the slave side is the skew feeder.
interface input_skew_feeder_if #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 4
);
   logic                  stall;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_last;
   logic [ROWS*WIDTH-1:0] in_data;
   logic [ROWS*WIDTH-1:0] out_data;
   logic                  out_en;
   logic                  busy;
   logic                  done;

   modport master (
      output stall, in_valid, in_last, in_data,
      input  in_ready, out_data, out_en, busy, done
   );

   modport slave (
      input  stall, in_valid, in_last, in_data,
      output in_ready, out_data, out_en, busy, done
   );
endinterface

// File: rtl/input_skew_feeder.sv
// Skews each accepted activation column into the diagonal wavefront the
// systolic array consumes, zero-flushes after the last beat and pulses done.
module input_skew_feeder #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 4
) (
   input  logic               CLK,
   input  logic               ASYNC_RST,
   input  logic               SYNC_RST,
   input_skew_feeder_if.slave bus
);

   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CNT_W-1:0]      drain_cnt;
   logic [CNT_W-1:0]      drain_cnt_next;
   logic                  done_next;
   logic                  accept;
   logic                  drain_adv;
   logic                  advance;
   logic [ROWS*WIDTH-1:0] col_in;
   logic [ROWS*WIDTH-1:0] out_data_q;
   logic                  out_en_q;
   logic                  done_q;

   // Readiness is masked by both resets so nothing is taken while either is held.
   assign bus.in_ready = (state != DRAIN) && !bus.stall && !SYNC_RST && ASYNC_RST;
   assign accept       = bus.in_valid && bus.in_ready;
   assign drain_adv    = (state == DRAIN) && !bus.stall && !SYNC_RST;
   assign advance      = accept || drain_adv;
   assign col_in       = accept ? bus.in_data : '0;

   assign bus.out_data = out_data_q;
   assign bus.out_en   = out_en_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state != IDLE);

   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      done_next      = 1'b0;
      case (state)
         IDLE, STREAM: begin
            if (accept) begin
               if (bus.in_last) begin
                  if (ROWS == 1) begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     state_next     = DRAIN;
                     drain_cnt_next = '0;
                  end
               end else begin
                  state_next = STREAM;
               end
            end
         end
         DRAIN: begin
            if (drain_adv) begin
               if (drain_cnt == DRAIN_LAST) begin
                  state_next     = IDLE;
                  drain_cnt_next = '0;
                  done_next      = 1'b1;
               end else begin
                  drain_cnt_next = drain_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         state     <= IDLE;
         drain_cnt <= '0;
         out_en_q  <= 1'b0;
         done_q    <= 1'b0;
      end else if (SYNC_RST) begin
         state     <= IDLE;
         drain_cnt <= '0;
         out_en_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
         out_en_q  <= advance;
         done_q    <= done_next;
      end
   end

   // Lane i holds i delay stages ahead of its output register; all shift
   // together on an advance, so a drain leaves only zeros behind.
   for (genvar i = 0; i < ROWS; i++) begin : g_lane
      logic [WIDTH-1:0] lane_in;
      logic [WIDTH-1:0] lane_q;

      assign lane_in = col_in[i*WIDTH +: WIDTH];
      assign out_data_q[i*WIDTH +: WIDTH] = lane_q;

      if (i == 0) begin : g_direct
         always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
               lane_q <= '0;
            end else if (SYNC_RST) begin
               lane_q <= '0;
            end else if (advance) begin
               lane_q <= lane_in;
            end
         end
      end else begin : g_delay
         logic [WIDTH-1:0] dly [i];

         always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
               for (int j = 0; j < i; j++) dly[j] <= '0;
               lane_q <= '0;
            end else if (SYNC_RST) begin
               for (int j = 0; j < i; j++) dly[j] <= '0;
               lane_q <= '0;
            end else if (advance) begin
               dly[0] <= lane_in;
               for (int j = 1; j < i; j++) dly[j] <= dly[j-1];
               lane_q <= dly[i-1];
            end
         end
      end
   end

endmodule
